// File: rtl/oscillo_readout.sv
// oscillo_readout: streams a finished capture out of the circular RAM, oldest pre-trigger sample first.
// Define OSCILLO_READOUT_HEADER_EN to prefix each readout with 0xA5 and the top byte of the base address.
module oscillo_readout #(
    parameter int ram_width  = 10,
    parameter int RAM_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 auto_rearm,
    input  logic                 data_ready,
    input  logic [ram_width-1:0] wraddress_triggerpoint,
    input  logic [ram_width-1:0] triggerpoint,
    input  logic [ram_width:0]   readout_len,
    output logic                 rden,
    output logic [ram_width-1:0] rdaddress,
    input  logic [7:0]           ram_q,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 startTrigger,
    output logic                 busy,
    output logic                 done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, WAIT, READ, DRAIN, DONE} state_t;

    state_t               state_q, state_d;
    logic [ram_width-1:0] addr_q, addr_d, base;
    logic [ram_width:0]   rem_q, rem_d;
    logic [CW-1:0]        infl_q, infl_d, cnt_q, cnt_d;
    logic [RAM_LAT-1:0]   sr_q, sr_d;
    logic [PW-1:0]        wp_q, wp_d, rp_q, rp_d;
    logic [7:0]           fifo_q [FIFO_DEPTH];
    logic [7:0]           fifo_d [FIFO_DEPTH];
    logic                 space, ret, pop, wr, hold, enter;
    logic [7:0]           wdata;

    assign base         = wraddress_triggerpoint - triggerpoint;
    assign enter        = state_q == WAIT && data_ready;
    assign ret          = sr_q[RAM_LAT-1];
    // Reserve a FIFO slot for every outstanding read so returns can never overflow it
    assign space        = ({1'b0, cnt_q} + {1'b0, infl_q}) < DEPTH_W;
    assign rden         = state_q == READ && rem_q != '0 && space && !hold;
    assign rdaddress    = rden ? addr_q : '0;
    assign tx_valid     = cnt_q != '0;
    assign tx_data      = tx_valid ? fifo_q[rp_q] : 8'h00;
    assign pop          = tx_valid && tx_ready;
    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
    assign startTrigger = done && auto_rearm;

`ifdef OSCILLO_READOUT_HEADER_EN
    logic [1:0] hdr_q, hdr_d;
    logic [7:0] hdr_byte_q, hdr_byte_d;

    assign hold  = hdr_q != 2'd0;
    assign wr    = ret || hold;
    assign wdata = ret ? ram_q : (hdr_q == 2'd2 ? 8'hA5 : hdr_byte_q);

    always_comb begin
        hdr_d      = enter ? 2'd2 : (hold ? hdr_q - 2'd1 : hdr_q);
        hdr_byte_d = enter ? base[ram_width-1 -: 8] : hdr_byte_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hdr_q      <= 2'd0;
            hdr_byte_q <= 8'h00;
        end else begin
            hdr_q      <= hdr_d;
            hdr_byte_q <= hdr_byte_d;
        end
    end
`else
    assign hold  = 1'b0;
    assign wr    = ret;
    assign wdata = ram_q;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = rden ? addr_q + ram_width'(1) : addr_q;
        rem_d   = rden ? rem_q - (ram_width + 1)'(1) : rem_q;
        infl_d  = infl_q + CW'(rden) - CW'(ret);
        sr_d    = RAM_LAT'({sr_q, rden});
        cnt_d   = cnt_q + CW'(wr) - CW'(pop);
        wp_d    = wr ? wp_q + PW'(1) : wp_q;
        rp_d    = pop ? rp_q + PW'(1) : rp_q;
        fifo_d  = fifo_q;
        if (wr) fifo_d[wp_q] = wdata;
        case (state_q)
            IDLE:    if (start) state_d = WAIT;
            WAIT:    if (data_ready) begin
                state_d = READ;
                addr_d  = base;
                rem_d   = readout_len == '0 ? {1'b1, {ram_width{1'b0}}} : readout_len;
            end
            READ:    if (rem_q == '0) state_d = DRAIN;
            DRAIN:   if (infl_q == '0 && cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            infl_q  <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            fifo_q  <= '{default: 8'h00};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            infl_q  <= infl_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            fifo_q  <= fifo_d;
        end
    end
endmodule

// File: tb/tb_oscillo_readout.sv
// tb_oscillo_readout: directed readouts against a RAM model holding RAM[i] = i[7:0].
module tb_oscillo_readout;
    localparam int W = 10;
`ifdef OSCILLO_READOUT_HEADER_EN
    localparam int HDR = 2;
    localparam int LAT = 3;
`else
    localparam int HDR = 0;
    localparam int LAT = 5;
`endif

    logic         clk = 1'b0, rstn = 1'b0, start = 1'b0, auto_rearm = 1'b0, data_ready = 1'b0;
    logic [W-1:0] wraddress_triggerpoint = '0, triggerpoint = '0;
    logic [W:0]   readout_len = '0;
    logic         rden, tx_valid, startTrigger, busy, done;
    logic         tx_ready = 1'b0;
    logic [W-1:0] rdaddress;
    logic [7:0]   ram_q, tx_data;
    logic [W-1:0] ra1 = '0;
    logic [7:0]   rq = 8'h00;

    int nerr = 0, nchk = 0, ready_pct = 100;
    int ndone, ntrig, stall_err, max_cnt, lat, busy_err, early;
    logic [W-1:0] addrs[$];
    logic [7:0]   bytes[$];
    logic         prev_stall = 1'b0;
    logic [7:0]   prev_data = 8'h00;

    oscillo_readout dut (
        .clk(clk), .rstn(rstn), .start(start), .auto_rearm(auto_rearm), .data_ready(data_ready),
        .wraddress_triggerpoint(wraddress_triggerpoint), .triggerpoint(triggerpoint),
        .readout_len(readout_len), .rden(rden), .rdaddress(rdaddress), .ram_q(ram_q),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .startTrigger(startTrigger), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Two-cycle RAM: address registered, then data registered
    always @(posedge clk) begin
        ra1 <= rdaddress;
        rq  <= ra1[7:0];
    end
    assign ram_q = rq;

    always @(posedge clk) #1 tx_ready = $urandom_range(99) < ready_pct;

    always @(negedge clk) begin
        if (rstn) begin
            if (rden) addrs.push_back(rdaddress);
            if (tx_valid && tx_ready) bytes.push_back(tx_data);
            if (done) ndone++;
            if (startTrigger) ntrig++;
            if (prev_stall && (!tx_valid || tx_data != prev_data)) stall_err++;
            if (int'(dut.cnt_q) > max_cnt) max_cnt = int'(dut.cnt_q);
        end
        prev_stall = rstn && tx_valid && !tx_ready;
        prev_data  = tx_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic readout(input string tag, input int wtp, input int tp, input int len,
                           input logic rearm, input int dr_delay);
        bit seen = 1'b0;
        addrs.delete();
        bytes.delete();
        ndone = 0; ntrig = 0; stall_err = 0; max_cnt = 0; lat = -1; busy_err = 0; early = 0;
        @(posedge clk); #1;
        wraddress_triggerpoint = W'(wtp);
        triggerpoint           = W'(tp);
        readout_len            = (W + 1)'(len);
        auto_rearm             = rearm;
        data_ready             = dr_delay == 0;
        start                  = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < dr_delay; i++) begin
            @(negedge clk);
            if (rden) early++;
            if (!busy) busy_err++;
        end
        if (dr_delay > 0) begin
            @(posedge clk); #1 data_ready = 1'b1;
        end
        for (int i = 1; i < 20000; i++) begin
            @(negedge clk);
            if (lat < 0 && tx_valid) lat = i;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 1);
        check({tag, "_busy_at_done"}, 32'(busy), 1);
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(busy), 0);
        check({tag, "_done_once"}, ndone, 1);
        check({tag, "_start_trigger"}, ntrig, 32'(rearm));
    endtask

    task automatic verify(input string tag, input int wtp, input int tp, input int len);
        int base = (wtp - tp) & 1023;
        int n    = len == 0 ? 1024 : len;
        int bad  = 0;
        check({tag, "_n_addr"}, addrs.size(), n);
        check({tag, "_n_bytes"}, bytes.size(), n + HDR);
        for (int i = 0; i < n; i++) begin
            if (i < addrs.size() && int'(addrs[i]) != ((base + i) & 1023)) bad++;
            if (i + HDR < bytes.size() && int'(bytes[i + HDR]) != ((base + i) & 255)) bad++;
        end
        check({tag, "_order"}, bad, 0);
        check({tag, "_first_addr"}, addrs.size() > 0 ? 32'(addrs[0]) : 32'hDEAD, base);
        check({tag, "_first_data"}, bytes.size() > HDR ? 32'(bytes[HDR]) : 32'hDEAD, base & 255);
`ifdef OSCILLO_READOUT_HEADER_EN
        check({tag, "_hdr0"}, bytes.size() > 0 ? 32'(bytes[0]) : 32'hDEAD, 32'hA5);
        check({tag, "_hdr1"}, bytes.size() > 1 ? 32'(bytes[1]) : 32'hDEAD, (base >> 2) & 255);
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({rden, rdaddress, tx_data, tx_valid, startTrigger, busy, done}), 0);
        rstn = 1'b1;

        readout("basic", 300, 100, 1024, 1'b1, 0);
        verify("basic", 300, 100, 1024);
        check("basic_latency", lat, LAT);

        readout("wrap", 5, 10, 20, 1'b0, 0);
        verify("wrap", 5, 10, 20);
        check("wrap_last_addr", addrs.size() == 20 ? 32'(addrs[19]) : 32'hDEAD, 14);

        ready_pct = 30;
        readout("bp", 100, 40, 64, 1'b1, 0);
        verify("bp", 100, 40, 64);
        check("bp_stall_stable", stall_err, 0);
        check("bp_fifo_bound", 32'(max_cnt <= 4), 1);
        ready_pct = 100;

        readout("wait", 500, 0, 32, 1'b0, 50);
        verify("wait", 500, 0, 32);
        check("wait_no_early_rden", early, 0);
        check("wait_busy_held", busy_err, 0);

        readout("len0", 0, 0, 0, 1'b1, 0);
        verify("len0", 0, 0, 0);
        readout("len1", 1023, 0, 1, 1'b0, 0);
        verify("len1", 1023, 0, 1);
        readout("hdr", 32'h2C8, 0, 16, 1'b0, 0);
        verify("hdr", 32'h2C8, 0, 16);

        addrs.delete();
        bytes.delete();
        ndone = 0;
        ntrig = 0;
        @(posedge clk); #1;
        wraddress_triggerpoint = W'(300);
        triggerpoint           = W'(100);
        readout_len            = (W + 1)'(64);
        auto_rearm             = 1'b1;
        data_ready             = 1'b1;
        start                  = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bytes.size() >= 10) break;
        end
        check("rst_progress", 32'(bytes.size() >= 10), 1);
        #2 rstn = 1'b0;
        @(negedge clk);
        check("rst_outputs", 32'({rden, rdaddress, tx_data, tx_valid, startTrigger, busy, done}), 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_no_done", ndone + ntrig, 0);
        check("rst_idle", 32'(busy), 0);
        readout("rerun", 300, 100, 64, 1'b0, 0);
        verify("rerun", 300, 100, 64);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
